// File: rtl/spi_flash_responder.sv
// spi_flash_responder
//   SPI mode-0 target that answers the serial NOR flash command subset used
//   by the memory controller: READ (03), PAGE PROGRAM (02), RDSR (05),
//   WREN (06), WRDI (04), RESET ENABLE (66) and RESET (99).
//   The flash array lives in an external synchronous byte RAM.
//   CSn, SCK and MOSI are oversampled by clk; SCK is never used as a clock.
//
// Ports
//   clk, rst_n            system clock, asynchronous active-low reset
//   CSn, SCK, MOSI        SPI inputs (mode 0, MSB first)
//   MISO                  SPI output, 0 whenever no data byte is shifting
//   mem_addr/mem_we/
//   mem_wdata/mem_rdata   backing RAM port, read data valid 1 clk after addr
//   wel                   write-enable latch
//   cmd_strobe/cmd_opcode one-clk pulse and value of each completed opcode
module spi_flash_responder #(
    parameter int ADDR_WIDTH  = 12,  // must be greater than 8 (page = 256 B)
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  CSn,
    input  logic                  SCK,
    input  logic                  MOSI,
    output logic                  MISO,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [7:0]            mem_wdata,
    input  logic [7:0]            mem_rdata,
    output logic                  wel,
    output logic                  cmd_strobe,
    output logic [7:0]            cmd_opcode
);

    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_PP    = 8'h02;
    localparam logic [7:0] OP_RDSR  = 8'h05;
    localparam logic [7:0] OP_WREN  = 8'h06;
    localparam logic [7:0] OP_WRDI  = 8'h04;
    localparam logic [7:0] OP_RSTEN = 8'h66;
    localparam logic [7:0] OP_RST   = 8'h99;
    localparam logic [ADDR_WIDTH-1:0] PAGE_MASK = ADDR_WIDTH'(8'hFF);

    typedef enum logic [2:0] {IDLE, OPCODE, ADDR, RD_DATA, PP_DATA, STAT, IGNORE} state_t;
    state_t state_reg, state_next;

    // Input synchronisers; CSn resets to its idle (deselected) level.
    logic [SYNC_STAGES-1:0] csn_sync_reg, sck_sync_reg, mosi_sync_reg;
    logic csn_d_reg, sck_d_reg;
    logic csn_s, sck_s, mosi_s;
    logic csn_rise, csn_fall, sck_rise, sck_fall;

    logic [4:0]            bit_cnt_reg;
    logic [6:0]            shift_in_reg;
    logic [7:0]            shift_out_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic                  miso_reg, mem_we_reg, wel_reg, rst_en_reg;
    logic                  cmd_strobe_reg;
    logic [7:0]            cmd_opcode_reg, mem_wdata_reg;
    logic [ADDR_WIDTH-1:0] mem_addr_reg;
    logic                  rd_p1_reg, rd_p2_reg;      // RAM read pipeline
    logic                  opcode_done_reg, extra_reg, wrote_reg;

    logic [7:0]            byte_in;
    logic [ADDR_WIDTH-1:0] addr_shifted, addr_inc, addr_page_inc;
    logic                  byte_done, addr_done, cmd_exact;
    logic [7:0]            status;

    assign csn_s    = csn_sync_reg[SYNC_STAGES-1];
    assign sck_s    = sck_sync_reg[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_reg[SYNC_STAGES-1];
    assign csn_rise = csn_s & ~csn_d_reg;
    assign csn_fall = ~csn_s & csn_d_reg;
    assign sck_rise = sck_s & ~sck_d_reg;
    assign sck_fall = ~sck_s & sck_d_reg;

    assign byte_in       = {shift_in_reg, mosi_s};
    assign byte_done     = sck_rise && (bit_cnt_reg == 5'd7);
    assign addr_done     = sck_rise && (bit_cnt_reg == 5'd23);
    assign addr_shifted  = {addr_reg[ADDR_WIDTH-2:0], mosi_s};
    assign addr_inc      = addr_reg + ADDR_WIDTH'(1);
    // Page program wraps inside the 256-byte page; upper bits stay put.
    assign addr_page_inc = (addr_reg & ~PAGE_MASK) | (addr_inc & PAGE_MASK);
    // Single-byte commands act only if no bit followed the opcode.
    assign cmd_exact     = opcode_done_reg & ~extra_reg;
    assign status        = {6'b0, wel_reg, 1'b0};

    assign MISO       = miso_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_we     = mem_we_reg;
    assign mem_wdata  = mem_wdata_reg;
    assign wel        = wel_reg;
    assign cmd_strobe = cmd_strobe_reg;
    assign cmd_opcode = cmd_opcode_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csn_sync_reg  <= '1;
            sck_sync_reg  <= '0;
            mosi_sync_reg <= '0;
            csn_d_reg     <= 1'b1;
            sck_d_reg     <= 1'b0;
        end else begin
            csn_sync_reg  <= {csn_sync_reg[SYNC_STAGES-2:0], CSn};
            sck_sync_reg  <= {sck_sync_reg[SYNC_STAGES-2:0], SCK};
            mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], MOSI};
            csn_d_reg     <= csn_s;
            sck_d_reg     <= sck_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // A deselected chip always returns to IDLE, whatever else happens.
    always_comb begin
        state_next = state_reg;
        if (csn_s) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:   if (csn_fall) state_next = OPCODE;
                OPCODE: if (byte_done) begin
                    case (byte_in)
                        OP_READ: state_next = ADDR;
                        OP_PP:   state_next = wel_reg ? ADDR : IGNORE;
                        OP_RDSR: state_next = STAT;
                        default: state_next = IGNORE;
                    endcase
                end
                ADDR:   if (addr_done)
                    state_next = (cmd_opcode_reg == OP_READ) ? RD_DATA : PP_DATA;
                default: state_next = state_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_reg     <= '0;
            shift_in_reg    <= '0;
            shift_out_reg   <= '0;
            addr_reg        <= '0;
            miso_reg        <= 1'b0;
            mem_we_reg      <= 1'b0;
            mem_addr_reg    <= '0;
            mem_wdata_reg   <= '0;
            wel_reg         <= 1'b0;
            rst_en_reg      <= 1'b0;
            cmd_strobe_reg  <= 1'b0;
            cmd_opcode_reg  <= '0;
            rd_p1_reg       <= 1'b0;
            rd_p2_reg       <= 1'b0;
            opcode_done_reg <= 1'b0;
            extra_reg       <= 1'b0;
            wrote_reg       <= 1'b0;
        end else begin
            mem_we_reg     <= 1'b0;
            cmd_strobe_reg <= 1'b0;
            rd_p1_reg      <= 1'b0;
            rd_p2_reg      <= rd_p1_reg;
            if (csn_s) begin
                // Deselected: drop any partial byte and pending fetch.
                bit_cnt_reg     <= '0;
                shift_out_reg   <= '0;
                miso_reg        <= 1'b0;
                rd_p2_reg       <= 1'b0;
                opcode_done_reg <= 1'b0;
                extra_reg       <= 1'b0;
                wrote_reg       <= 1'b0;
                if (csn_rise) begin
                    if (wrote_reg) wel_reg <= 1'b0;
                    if (opcode_done_reg) begin
                        rst_en_reg <= cmd_exact && (cmd_opcode_reg == OP_RSTEN);
                        if (cmd_exact) begin
                            case (cmd_opcode_reg)
                                OP_WREN: wel_reg <= 1'b1;
                                OP_WRDI: wel_reg <= 1'b0;
                                OP_RST:  if (rst_en_reg) wel_reg <= 1'b0;
                                default: ;
                            endcase
                        end
                    end
                end
            end else if (state_reg == IDLE) begin
                bit_cnt_reg   <= '0;
                shift_out_reg <= '0;
            end else begin
                // RAM data lands two clks after the address is issued.
                if (rd_p2_reg) begin
                    shift_out_reg <= mem_rdata;
                end else if (sck_fall) begin
                    miso_reg      <= shift_out_reg[7];
                    shift_out_reg <= {shift_out_reg[6:0], 1'b0};
                end
                if (sck_rise) begin
                    shift_in_reg <= byte_in[6:0];
                    if (opcode_done_reg) extra_reg <= 1'b1;
                    if ((state_reg == ADDR) ? addr_done : byte_done) bit_cnt_reg <= '0;
                    else                                            bit_cnt_reg <= bit_cnt_reg + 5'd1;
                    case (state_reg)
                        OPCODE: if (byte_done) begin
                            cmd_strobe_reg  <= 1'b1;
                            cmd_opcode_reg  <= byte_in;
                            opcode_done_reg <= 1'b1;
                            if (byte_in == OP_RDSR) shift_out_reg <= status;
                        end
                        ADDR: begin
                            addr_reg <= addr_shifted;
                            if (addr_done && (cmd_opcode_reg == OP_READ)) begin
                                mem_addr_reg <= addr_shifted;
                                rd_p1_reg    <= 1'b1;
                            end
                        end
                        RD_DATA: if (byte_done) begin
                            addr_reg     <= addr_inc;
                            mem_addr_reg <= addr_inc;
                            rd_p1_reg    <= 1'b1;
                        end
                        PP_DATA: if (byte_done) begin
                            mem_we_reg    <= 1'b1;
                            mem_addr_reg  <= addr_reg;
                            mem_wdata_reg <= byte_in;
                            addr_reg      <= addr_page_inc;
                            wrote_reg     <= 1'b1;
                        end
                        STAT: if (byte_done) shift_out_reg <= status;
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
// tb_spi_flash_responder
//   Drives SPI frames into spi_flash_responder and checks MISO bytes, RAM
//   writes, opcode strobes, wel and cmd_opcode against a frame-level model.
`timescale 1ns/1ps
module tb_spi_flash_responder;

    localparam int MEM  = 4096;
    localparam int HALF = 6;   // SCK half period in clk cycles

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        CSn = 1'b1;
    logic        SCK = 1'b0;
    logic        MOSI = 1'b0;
    logic        MISO;
    logic [11:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        wel;
    logic        cmd_strobe;
    logic [7:0]  cmd_opcode;

    spi_flash_responder #(.ADDR_WIDTH(12), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .CSn(CSn), .SCK(SCK), .MOSI(MOSI), .MISO(MISO),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .wel(wel), .cmd_strobe(cmd_strobe),
        .cmd_opcode(cmd_opcode)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         addr;
        logic [7:0] data;
    } wr_t;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] model_mem [MEM];
    logic       model_wel = 1'b0;
    logic       model_rst_en = 1'b0;
    logic       model_wrote = 1'b0;
    logic [7:0] model_last_op = 8'h00;
    logic [7:0] frame_q [$];
    logic [7:0] exp_miso [$];
    logic [7:0] exp_cmd [$];
    wr_t        exp_wr [$];
    logic       preload = 1'b0;
    logic [7:0] ram [MEM];

    // Backing RAM: registered read, written by the DUT.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < MEM; i++) ram[i] <= model_mem[i];
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: MISO bytes as seen by a mode-0 controller.
    int         mon_cnt = 0;
    logic [7:0] mon_byte = 8'h00;
    always @(posedge SCK or posedge CSn) begin
        if (CSn) begin
            mon_cnt = 0;
        end else begin
            mon_byte = {mon_byte[6:0], MISO};
            mon_cnt++;
            if (mon_cnt == 8) begin
                mon_cnt = 0;
                if (exp_miso.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL miso_byte unexpected actual=0x%02h required=none", mon_byte);
                end else begin
                    check("miso_byte", {24'h0, mon_byte}, {24'h0, exp_miso.pop_front()});
                end
            end
        end
    end

    // Monitor: RAM write strobes and opcode strobes.
    always @(negedge clk) begin
        if (mem_we) begin
            if (exp_wr.size() == 0) begin
                checks++; failures++;
                $display("FAIL mem_we unexpected addr=0x%03h data=0x%02h required=none", mem_addr, mem_wdata);
            end else begin
                wr_t w;
                w = exp_wr.pop_front();
                check("wr_addr", {20'h0, mem_addr}, w.addr);
                check("wr_data", {24'h0, mem_wdata}, {24'h0, w.data});
            end
        end
        if (cmd_strobe) begin
            if (exp_cmd.size() == 0) begin
                checks++; failures++;
                $display("FAIL cmd_strobe unexpected opcode=0x%02h required=none", cmd_opcode);
            end else begin
                check("cmd_strobe_op", {24'h0, cmd_opcode}, {24'h0, exp_cmd.pop_front()});
            end
        end
    end

    // Frame-level model: what every full byte, write and strobe should be.
    task automatic model_frame(input int nbits);
        int nb, a, wa;
        logic [7:0] op, e;
        logic wel0;
        wr_t w;
        nb = nbits / 8;
        model_wrote = 1'b0;
        if (nbits < 8) return;
        op = frame_q[0];
        wel0 = model_wel;
        exp_cmd.push_back(op);
        a = ((int'(frame_q[1]) << 16) | (int'(frame_q[2]) << 8) | int'(frame_q[3])) % MEM;
        for (int k = 0; k < nb; k++) begin
            e = 8'h00;
            if (op == 8'h03 && k >= 4) begin
                e = model_mem[(a + k - 4) % MEM];
            end else if (op == 8'h05 && k >= 1) begin
                e = wel0 ? 8'h02 : 8'h00;
            end else if (op == 8'h02 && wel0 && k >= 4) begin
                wa = (a / 256) * 256 + ((a + k - 4) % 256);
                w.addr = wa;
                w.data = frame_q[k];
                exp_wr.push_back(w);
                model_mem[wa] = frame_q[k];
                model_wrote = 1'b1;
            end
            exp_miso.push_back(e);
        end
    endtask

    task automatic model_commit(input int nbits);
        logic exact;
        logic [7:0] op;
        if (nbits < 8) return;
        op = frame_q[0];
        model_last_op = op;
        exact = (nbits == 8);
        if (model_wrote) model_wel = 1'b0;
        if (exact && op == 8'h06) model_wel = 1'b1;
        if (exact && op == 8'h04) model_wel = 1'b0;
        if (exact && op == 8'h99 && model_rst_en) model_wel = 1'b0;
        model_rst_en = exact && (op == 8'h66);
    endtask

    task automatic drive_bits(input int nbits);
        CSn = 1'b0;
        wait_clks(HALF);
        for (int i = 0; i < nbits; i++) begin
            MOSI = frame_q[i / 8][7 - (i % 8)];
            wait_clks(HALF);
            SCK = 1'b1;
            wait_clks(HALF);
            SCK = 1'b0;
        end
    endtask

    task automatic end_frame();
        wait_clks(HALF);
        MOSI = 1'b0;
        CSn = 1'b1;
        wait_clks(4 * HALF);
    endtask

    task automatic run_frame(input int nbits);
        while (frame_q.size() < 4) frame_q.push_back(8'h00);
        model_frame(nbits);
        drive_bits(nbits);
        end_frame();
        model_commit(nbits);
        check("wel", {31'h0, wel}, {31'h0, model_wel});
        check("cmd_opcode", {24'h0, cmd_opcode}, {24'h0, model_last_op});
        $display("frame op=0x%02h bits=%0d wel=%0d cmd_opcode=0x%02h", frame_q[0], nbits, wel, cmd_opcode);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < MEM; i++) model_mem[i] = 8'($urandom_range(0, 255));
        model_mem[12'hFFF] = 8'h5A;
        model_mem[12'h000] = 8'hA5;
        preload = 1'b1;
        wait_clks(2);
        preload = 1'b0;
        wait_clks(2);

        check("rst_miso", {31'h0, MISO}, 32'h0);
        check("rst_mem_we", {31'h0, mem_we}, 32'h0);
        check("rst_mem_addr", {20'h0, mem_addr}, 32'h0);
        check("rst_mem_wdata", {24'h0, mem_wdata}, 32'h0);
        check("rst_wel", {31'h0, wel}, 32'h0);
        check("rst_cmd_strobe", {31'h0, cmd_strobe}, 32'h0);
        check("rst_cmd_opcode", {24'h0, cmd_opcode}, 32'h0);
        rst_n = 1'b1;
        wait_clks(4);

        // WREN then RDSR over two status bytes.
        frame_q = {8'h06};                              run_frame(8);
        frame_q = {8'h05, 8'h00, 8'h00};                run_frame(24);
        // Program with wel clear is ignored.
        frame_q = {8'h04};                              run_frame(8);
        frame_q = {8'h02, 8'h00, 8'h00, 8'h10, 8'hAA};  run_frame(40);
        // Program across the page end wraps to the page start.
        frame_q = {8'h06};                              run_frame(8);
        frame_q = {8'h02, 8'h00, 8'h01, 8'hFE, 8'h11, 8'h22, 8'h33}; run_frame(56);
        // Read across the top of the array wraps to 0.
        frame_q = {8'h03, 8'h00, 8'h0F, 8'hFF, 8'h00, 8'h00}; run_frame(48);
        // Aborted WREN, then status.
        frame_q = {8'h06};                              run_frame(5);
        frame_q = {8'h05, 8'h00};                       run_frame(16);
        // Reset needs 66 immediately before 99.
        frame_q = {8'h06};                              run_frame(8);
        frame_q = {8'h99};                              run_frame(8);
        frame_q = {8'h66};                              run_frame(8);
        frame_q = {8'h99};                              run_frame(8);

        // rst_n pulsed in the middle of a read.
        frame_q = {8'h06};                              run_frame(8);
        frame_q = {8'h03, 8'h00, 8'h02, 8'h34, 8'h00, 8'h00};
        model_frame(44);
        drive_bits(44);
        rst_n = 1'b0;
        #1;
        check("midrst_miso", {31'h0, MISO}, 32'h0);
        check("midrst_wel", {31'h0, wel}, 32'h0);
        check("midrst_mem_we", {31'h0, mem_we}, 32'h0);
        check("midrst_cmd_opcode", {24'h0, cmd_opcode}, 32'h0);
        $display("reset asserted mid-read wel=%0d miso=%0d", wel, MISO);
        end_frame();
        rst_n = 1'b1;
        model_wel = 1'b0;
        model_rst_en = 1'b0;
        model_last_op = 8'h00;
        wait_clks(4);
        frame_q = {8'h05, 8'h00};                       run_frame(16);

        // Randomized frames.
        for (int n = 0; n < 40; n++) begin
            int kind, len, cut;
            logic [7:0] op;
            kind = int'($urandom_range(0, 7));
            case (kind)
                0: op = 8'h03;
                1: op = 8'h02;
                2: op = 8'h05;
                3: op = 8'h06;
                4: op = 8'h04;
                5: op = 8'h66;
                6: op = 8'h99;
                default: op = 8'($urandom_range(0, 255));
            endcase
            case (kind)
                0: len = 4 + int'($urandom_range(1, 3));
                1: len = 4 + int'($urandom_range(0, 3));
                2: len = 1 + int'($urandom_range(1, 2));
                default: len = ($urandom_range(0, 3) == 0) ? 2 : 1;
            endcase
            frame_q.delete();
            frame_q.push_back(op);
            for (int j = 1; j < len; j++) frame_q.push_back(8'($urandom_range(0, 255)));
            cut = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 7)) : 0;
            run_frame(8 * len - cut);
        end

        wait_clks(20);
        check("miso_q_left", exp_miso.size(), 32'h0);
        check("wr_q_left", exp_wr.size(), 32'h0);
        check("cmd_q_left", exp_cmd.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_flash_responder.md
Name: spi_flash_responder

Overview:
- SPI mode-0 target that emulates the serial NOR flash command set the on-chip memory controller issues (READ, PAGE PROGRAM, WREN, WRDI, RDSR, reset-enable/reset).
- Backs the flash array with an external synchronous byte RAM port, so the controller can be exercised on-board without a physical flash part.
- Inputs are oversampled by clk; SCK is never used as a clock.

Parameters:
- ADDR_WIDTH, 12, byte-address width of backing RAM; the 24-bit SPI address is truncated to its low ADDR_WIDTH bits.
- SYNC_STAGES, 2, synchroniser depth on CSn, SCK and MOSI (minimum 2).

Ports:
- clk  input  1  system clock; frequency ≥ 8× SCK.
- rst_n  input  1  reset, asynchronous, active-low.
- CSn  input  1  SPI chip select, active-low.
- SCK  input  1  SPI clock, mode 0; idles low.
- MOSI  input  1  controller-to-target data, MSB first.
- MISO  output  1  target-to-controller data; 0 when not driving data.
- mem_addr  output  ADDR_WIDTH  backing-RAM byte address.
- mem_we  output  1  one-cycle write strobe.
- mem_wdata  output  8  write byte.
- mem_rdata  input  8  read byte, valid 1 clk after mem_addr.
- wel  output  1  write-enable latch.
- cmd_strobe  output  1  one-cycle pulse when an opcode byte completes.
- cmd_opcode  output  8  last completed opcode.

Behaviour:
- Reset values: MISO=0, mem_we=0, mem_addr=0, mem_wdata=0, wel=0, cmd_strobe=0, cmd_opcode=0, rst_en=0, FSM=IDLE.
- Synchronised SCK rise: sample MOSI into shift_in, bit_cnt++. Synchronised SCK fall: MISO ← shift_out[7], shift_out <<= 1.
- Synchronised CSn high: FSM→IDLE and bit_cnt=0 immediately, from any state. Any partial byte is discarded.
- FSM states: IDLE, OPCODE, ADDR, RD_DATA, PP_DATA, STAT, IGNORE.
- IDLE→OPCODE on CSn fall.
- OPCODE: after 8 bits, pulse cmd_strobe and latch cmd_opcode, then decode:
  - 03 → ADDR (read)
  - 02 → ADDR if wel=1, else IGNORE
  - 05 → STAT
  - 06, 04, 66, 99 → IGNORE; their action is committed at CSn rise only if exactly 8 bits were clocked
  - any other opcode → IGNORE
- ADDR: 24 bits, MSB first; addr ← low ADDR_WIDTH bits.
  - Read: on the 24th bit, issue mem_addr=addr. Next clk, load shift_out=mem_rdata. The MSB appears on MISO at the next SCK fall.
  - Program: on the 24th bit, go to PP_DATA.
- RD_DATA:
  - After each 8th bit, addr increments modulo 2^ADDR_WIDTH.
  - The next byte is prefetched and loaded into shift_out before the next SCK fall.
  - Data streams indefinitely until CSn rises.
- PP_DATA:
  - Each complete byte asserts mem_we for 1 clk with mem_addr=addr and mem_wdata=byte.
  - addr[7:0] increments and wraps within the 256-byte page; upper address bits are held.
  - At CSn rise, wel is cleared if ≥1 byte was written.
- STAT: shift_out reloads each byte with {6'b0, wel, 1'b0}; WIP always reads 0.
- Commits at CSn rise (8-bit-exact commands only):
  - 06: wel=1.
  - 04: wel=0.
  - 66: rst_en=1.
  - 99 with rst_en=1: wel=0, rst_en=0.
  - Any other completed command clears rst_en.
- Simultaneous CSn rise and SCK edge in the same clk: CSn wins; no bit is sampled.
- rst_n assertion mid-transfer: all outputs return to reset values immediately. Any in-flight mem_we is dropped.

Test Plan:
- WREN (06) frame, then RDSR (05) clocking 2 bytes → MISO returns 0x02, 0x02; wel=1.
- wel=0, frame 02 00 00 10 AA → no mem_we pulse; cmd_opcode=0x02; wel stays 0.
- WREN, then 02 00 01 FE 11 22 33 → writes 0x1FE=11, 0x1FF=22, 0x100=33 (page wrap); wel=0 after CSn rise.
- RAM 0xFFF=5A, 0x000=A5; frame 03 00 0F FF plus 16 clocks → MISO bytes 5A, A5 (ADDR_WIDTH=12 wrap).
- WREN frame aborted after 5 bits (CSn high) → wel unchanged, no cmd_strobe. Next frame 05 → status decodes correctly.
- wel=1: 99 alone → wel stays 1. 66 then 99 → wel=0. rst_n pulsed mid-READ → MISO=0, FSM IDLE, next frame works.
